// File: rtl/datapath_mc.sv
// rtl/datapath_mc.sv - multi-cycle RV32I/RV32E datapath with LSU, bus timeout and sticky trap
module datapath_mc #(
    parameter int          NREGS       = 32,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rfwrite,
    input  logic        use_imm,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  sel_pc,
    input  logic [1:0]  wb_sel,
    input  logic [2:0]  op_extend,
    input  logic [2:0]  br_type,
    input  logic [3:0]  alu_op,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [6:0]  opcode,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_mask,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam int RW = $clog2(NREGS);

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] rf [NREGS];
    logic [31:0] alu_q, wdata_q, ld_q;
    logic [3:0]  mask_q;
    logic        we_q, taken_q, rfwrite_q;
    logic [1:0]  wb_sel_q;
    logic [7:0]  tcnt;

    logic [4:0]  rs1a, rs2a, rda;
    logic [31:0] rs1v, rs2v, imm, op1, op2, alu_y, pc_plus4, ld_val, ld_sh, wb_data;
    logic [3:0]  mask_d;
    logic [31:0] wdata_d;
    logic        taken, misaligned, bad_reg, tmo;

    function automatic logic [31:0] rdreg(input logic [4:0] a);
        if (a == 5'd0 || int'(a) >= NREGS) return 32'd0;
        return rf[a[RW-1:0]];
    endfunction

    assign rs1a   = ir[19:15];
    assign rs2a   = ir[24:20];
    assign rda    = ir[11:7];
    assign func3  = ir[14:12];
    assign func7  = ir[31:25];
    assign opcode = ir[6:0];

    // Handshake strobes depend on the state register only, so reset drops them at once.
    assign imem_req   = (state == S_FETCH);
    assign imem_addr  = pc;
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = (state == S_MEM) && we_q;
    assign dmem_mask  = (state == S_MEM) ? mask_q : 4'b0000;
    assign dmem_addr  = alu_q;
    assign dmem_wdata = wdata_q;
    assign retire     = (state == S_WB);
    assign trap       = (state == S_TRAP);
    assign pc_plus4   = pc + 32'd4;
    assign tmo        = (tcnt == 8'(BUS_TIMEOUT - 1));

    always_comb begin
        rs1v = rdreg(rs1a);
        rs2v = rdreg(rs2a);

        case (op_extend)
            3'b000:  imm = {{20{ir[31]}}, ir[31:20]};
            3'b001:  imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            3'b010:  imm = {ir[31:12], 12'b0};
            3'b011:  imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            3'b100:  imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = 32'd0;
        endcase

        case (sel_pc)
            2'b00:   op1 = rs1v;
            2'b01:   op1 = pc;
            default: op1 = 32'd0;
        endcase
        op2 = use_imm ? imm : rs2v;

        case (alu_op)
            4'd0:    alu_y = op1 + op2;
            4'd1:    alu_y = op1 - op2;
            4'd2:    alu_y = op1 << op2[4:0];
            4'd3:    alu_y = {31'd0, $signed(op1) < $signed(op2)};
            4'd4:    alu_y = {31'd0, op1 < op2};
            4'd5:    alu_y = op1 ^ op2;
            4'd6:    alu_y = op1 >> op2[4:0];
            4'd7:    alu_y = $signed(op1) >>> op2[4:0];
            4'd8:    alu_y = op1 | op2;
            4'd9:    alu_y = op1 & op2;
            4'd10:   alu_y = op2;
            default: alu_y = 32'd0;
        endcase

        case (br_type)
            3'd1:    taken = (rs1v == rs2v);
            3'd2:    taken = (rs1v != rs2v);
            3'd3:    taken = ($signed(rs1v) < $signed(rs2v));
            3'd4:    taken = ($signed(rs1v) >= $signed(rs2v));
            3'd5:    taken = (rs1v < rs2v);
            3'd6:    taken = (rs1v >= rs2v);
            3'd7:    taken = 1'b1;
            default: taken = 1'b0;
        endcase

        // Only fields the current control word actually uses are range-checked.
        bad_reg = ((sel_pc == 2'b00) && int'(rs1a) >= NREGS)
               || ((!use_imm || mem_wr || (br_type != 3'd0 && br_type != 3'd7)) && int'(rs2a) >= NREGS)
               || (rfwrite && int'(rda) >= NREGS);

        misaligned = (mem_rd || mem_wr)
                  && ((func3[1:0] == 2'b10 && alu_y[1:0] != 2'b00)
                   || (func3[1:0] == 2'b01 && alu_y[0]));

        case (func3[1:0])
            2'b00: begin
                mask_d  = 4'b0001 << alu_y[1:0];
                wdata_d = {4{rs2v[7:0]}};
            end
            2'b01: begin
                mask_d  = 4'b0011 << {alu_y[1], 1'b0};
                wdata_d = {2{rs2v[15:0]}};
            end
            default: begin
                mask_d  = 4'b1111;
                wdata_d = rs2v;
            end
        endcase

        ld_sh = dmem_rdata >> {alu_q[1:0], 3'b000};
        case (func3)
            3'b000:  ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b100:  ld_val = {24'd0, ld_sh[7:0]};
            3'b101:  ld_val = {16'd0, ld_sh[15:0]};
            default: ld_val = dmem_rdata;
        endcase

        case (wb_sel_q)
            2'b01:   wb_data = ld_q;
            2'b10:   wb_data = pc_plus4;
            default: wb_data = alu_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_RST;
            pc         <= RESET_PC;
            ir         <= 32'd0;
            alu_q      <= 32'd0;
            wdata_q    <= 32'd0;
            ld_q       <= 32'd0;
            mask_q     <= 4'd0;
            we_q       <= 1'b0;
            taken_q    <= 1'b0;
            rfwrite_q  <= 1'b0;
            wb_sel_q   <= 2'b00;
            tcnt       <= 8'd0;
            trap_cause <= 2'b00;
            for (int i = 0; i < NREGS; i++) rf[i] <= 32'd0;
        end else begin
            case (state)
                S_RST: begin
                    tcnt  <= 8'd0;
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        tcnt  <= 8'd0;
                        state <= S_EXEC;
                    end else if (tmo) begin
                        trap_cause <= 2'b10;
                        state      <= S_TRAP;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    tcnt <= 8'd0;
                    if (bad_reg) begin
                        trap_cause <= 2'b11;
                        state      <= S_TRAP;
                    end else if (misaligned) begin
                        trap_cause <= 2'b01;
                        state      <= S_TRAP;
                    end else begin
                        alu_q     <= alu_y;
                        wdata_q   <= wdata_d;
                        mask_q    <= mask_d;
                        we_q      <= mem_wr;
                        taken_q   <= taken;
                        rfwrite_q <= rfwrite;
                        wb_sel_q  <= wb_sel;
                        state     <= (mem_rd || mem_wr) ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        ld_q  <= ld_val;
                        tcnt  <= 8'd0;
                        state <= S_WB;
                    end else if (tmo) begin
                        trap_cause <= 2'b10;
                        state      <= S_TRAP;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_WB: begin
                    if (rfwrite_q && rda != 5'd0) rf[rda[RW-1:0]] <= wb_data;
                    pc    <= taken_q ? {alu_q[31:1], 1'b0} : pc_plus4;
                    tcnt  <= 8'd0;
                    state <= S_FETCH;
                end
                default: state <= S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_mc.sv
// tb/tb_datapath_mc.sv - scoreboard bench for datapath_mc (RV32I and RV32E instances)
module tb_datapath_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rfwrite, use_imm, mem_rd, mem_wr;
        logic [1:0] sel_pc, wb_sel;
        logic [2:0] op_extend, br_type;
        logic [3:0] alu_op;
    } ctl_t;

    typedef struct packed { logic [31:0] addr, data; logic [3:0] mask; } st_t;
    typedef struct packed { logic [31:0] pc, lat; } rt_t;

    int errors = 0;
    int checks = 0;
    st_t st_q[$];
    rt_t rt_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        ctl_t c = '0;
        case (op)
            7'b0010011, 7'b0110011: begin
                c.rfwrite = 1'b1;
                c.use_imm = (op == 7'b0010011);
                case (f3)
                    3'd0:    c.alu_op = (!c.use_imm && f7[5]) ? 4'd1 : 4'd0;
                    3'd1:    c.alu_op = 4'd2;
                    3'd2:    c.alu_op = 4'd3;
                    3'd3:    c.alu_op = 4'd4;
                    3'd4:    c.alu_op = 4'd5;
                    3'd5:    c.alu_op = f7[5] ? 4'd7 : 4'd6;
                    3'd6:    c.alu_op = 4'd8;
                    default: c.alu_op = 4'd9;
                endcase
            end
            7'b0000011: begin
                c.rfwrite = 1'b1; c.use_imm = 1'b1; c.mem_rd = 1'b1; c.wb_sel = 2'b01;
            end
            7'b0100011: begin
                c.use_imm = 1'b1; c.mem_wr = 1'b1; c.op_extend = 3'b001;
            end
            7'b1100011: begin
                c.sel_pc = 2'b01; c.use_imm = 1'b1; c.op_extend = 3'b011;
                case (f3)
                    3'b000:  c.br_type = 3'd1;
                    3'b001:  c.br_type = 3'd2;
                    3'b100:  c.br_type = 3'd3;
                    3'b101:  c.br_type = 3'd4;
                    3'b110:  c.br_type = 3'd5;
                    default: c.br_type = 3'd6;
                endcase
            end
            7'b1101111: begin
                c.rfwrite = 1'b1; c.sel_pc = 2'b01; c.use_imm = 1'b1; c.op_extend = 3'b100;
                c.br_type = 3'd7; c.wb_sel = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] v = imm;
        return {v[11:0], 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input int rs2, input int rs1, input int rd);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
        logic [31:0] v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), f3, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
        logic [31:0] v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction

    task automatic exp_ret(input logic [31:0] p, input logic [31:0] lat);
        rt_q.push_back({p, lat});
    endtask

    task automatic exp_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        st_q.push_back({a, d, m});
    endtask

    // Instance A: RV32I with memory models
    logic        reset_a, dmem_en;
    ctl_t        ca;
    logic [2:0]  func3_a;
    logic [6:0]  func7_a, opcode_a;
    logic        imem_req_a, imem_ack_a, dmem_req_a, dmem_we_a, dmem_ack_a, retire_a, trap_a;
    logic [31:0] imem_addr_a, imem_rdata_a, dmem_addr_a, dmem_wdata_a, dmem_rdata_a, pc_a;
    logic [3:0]  dmem_mask_a;
    logic [1:0]  trap_cause_a;
    logic [31:0] prog_a [64];
    logic [31:0] dmem_a [64] = '{default: 32'h0};

    always_comb ca = decode(opcode_a, func3_a, func7_a);
    assign imem_ack_a   = imem_req_a;
    assign imem_rdata_a = prog_a[imem_addr_a[7:2]];
    assign dmem_ack_a   = dmem_req_a & dmem_en;
    assign dmem_rdata_a = dmem_a[dmem_addr_a[7:2]];

    always @(posedge clk) begin
        if (dmem_req_a && dmem_we_a && dmem_ack_a)
            for (int b = 0; b < 4; b++)
                if (dmem_mask_a[b]) dmem_a[dmem_addr_a[7:2]][8*b +: 8] <= dmem_wdata_a[8*b +: 8];
    end

    datapath_mc #(.NREGS(32), .RESET_PC(32'h0), .BUS_TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset_a),
        .rfwrite(ca.rfwrite), .use_imm(ca.use_imm), .mem_rd(ca.mem_rd), .mem_wr(ca.mem_wr),
        .sel_pc(ca.sel_pc), .wb_sel(ca.wb_sel), .op_extend(ca.op_extend), .br_type(ca.br_type),
        .alu_op(ca.alu_op), .func3(func3_a), .func7(func7_a), .opcode(opcode_a),
        .imem_req(imem_req_a), .imem_addr(imem_addr_a), .imem_ack(imem_ack_a), .imem_rdata(imem_rdata_a),
        .dmem_req(dmem_req_a), .dmem_we(dmem_we_a), .dmem_mask(dmem_mask_a), .dmem_addr(dmem_addr_a),
        .dmem_wdata(dmem_wdata_a), .dmem_ack(dmem_ack_a), .dmem_rdata(dmem_rdata_a),
        .pc(pc_a), .retire(retire_a), .trap(trap_a), .trap_cause(trap_cause_a)
    );

    // Instance B: RV32E
    logic        reset_b;
    ctl_t        cb;
    logic [2:0]  func3_b;
    logic [6:0]  func7_b, opcode_b;
    logic        imem_req_b, dmem_req_b, dmem_we_b, retire_b, trap_b;
    logic [31:0] imem_addr_b, dmem_addr_b, dmem_wdata_b, pc_b;
    logic [3:0]  dmem_mask_b;
    logic [1:0]  trap_cause_b;
    logic [31:0] prog_b [4];

    always_comb cb = decode(opcode_b, func3_b, func7_b);

    datapath_mc #(.NREGS(16), .RESET_PC(32'h0), .BUS_TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset_b),
        .rfwrite(cb.rfwrite), .use_imm(cb.use_imm), .mem_rd(cb.mem_rd), .mem_wr(cb.mem_wr),
        .sel_pc(cb.sel_pc), .wb_sel(cb.wb_sel), .op_extend(cb.op_extend), .br_type(cb.br_type),
        .alu_op(cb.alu_op), .func3(func3_b), .func7(func7_b), .opcode(opcode_b),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_req_b),
        .imem_rdata(prog_b[imem_addr_b[3:2]]),
        .dmem_req(dmem_req_b), .dmem_we(dmem_we_b), .dmem_mask(dmem_mask_b), .dmem_addr(dmem_addr_b),
        .dmem_wdata(dmem_wdata_b), .dmem_ack(dmem_req_b), .dmem_rdata(32'h0),
        .pc(pc_b), .retire(retire_b), .trap(trap_b), .trap_cause(trap_cause_b)
    );

    int  cyc = 0;
    int  last_ret = -1;
    int  loads_a = 0;
    int  stores_b = 0;
    st_t s;
    rt_t r;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset_a && dmem_req_a && dmem_ack_a) begin
            if (!dmem_we_a) loads_a++;
            else if (st_q.size() == 0) check("st_extra", dmem_addr_a, 32'hffff_ffff);
            else begin
                s = st_q.pop_front();
                check("st_addr", dmem_addr_a, s.addr);
                check("st_data", dmem_wdata_a, s.data);
                check("st_mask", {28'd0, dmem_mask_a}, {28'd0, s.mask});
            end
        end
        if (!reset_a && retire_a) begin
            if (rt_q.size() == 0) check("ret_extra", pc_a, 32'hffff_ffff);
            else begin
                r = rt_q.pop_front();
                check("ret_pc", pc_a, r.pc);
                if (last_ret >= 0) check("ret_gap", cyc - last_ret, r.lat);
            end
            last_ret = cyc;
        end
        if (!reset_b && dmem_req_b && dmem_we_b) begin
            stores_b++;
            check("b_st_addr", dmem_addr_b, 32'h40);
            check("b_x0_data", dmem_wdata_b, 32'h0);
        end
    end

    logic [31:0] hold_pc;
    int          reqcyc;
    logic        found;

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        dmem_en = 1'b1;
        for (int i = 0; i < 64; i++) prog_a[i] = enc_s(32'h80, 0, 0, 3'b010);

        prog_a[0]  = enc_i(5, 0, 3'b000, 1, 7'b0010011);      exp_ret(32'h00, 3);
        prog_a[1]  = enc_r(1, 1, 2);                           exp_ret(32'h04, 3);
        prog_a[2]  = enc_s(32'h40, 2, 0, 3'b010);              exp_ret(32'h08, 4);
        prog_a[3]  = enc_i(5, 5, 3'b000, 5, 7'b0010011);      exp_ret(32'h0C, 3);
        prog_a[4]  = enc_b(-8, 1, 5, 3'b000);                  exp_ret(32'h10, 3);
                                                               exp_ret(32'h08, 4);
                                                               exp_ret(32'h0C, 3);
                                                               exp_ret(32'h10, 3);
        prog_a[5]  = enc_i(32'h80, 0, 3'b000, 2, 7'b0010011); exp_ret(32'h14, 3);
        prog_a[6]  = enc_s(3, 2, 0, 3'b000);                   exp_ret(32'h18, 4);
        prog_a[7]  = enc_i(3, 0, 3'b000, 3, 7'b0000011);      exp_ret(32'h1C, 4);
        prog_a[8]  = enc_j(16, 1);                             exp_ret(32'h20, 3);
        prog_a[12] = enc_s(32'h44, 1, 0, 3'b010);              exp_ret(32'h30, 4);
        prog_a[13] = enc_s(32'h48, 3, 0, 3'b010);              exp_ret(32'h34, 4);
        prog_a[14] = enc_i(3, 0, 3'b100, 4, 7'b0000011);      exp_ret(32'h38, 4);
        prog_a[15] = enc_s(32'h4C, 4, 0, 3'b010);              exp_ret(32'h3C, 4);
        prog_a[16] = enc_s(6, 2, 0, 3'b001);                   exp_ret(32'h40, 4);
        prog_a[17] = enc_i(32'h102, 0, 3'b010, 8, 7'b0000011);

        exp_st(32'h40, 32'h0000_000A, 4'b1111);
        exp_st(32'h40, 32'h0000_000A, 4'b1111);
        exp_st(32'h03, 32'h8080_8080, 4'b1000);
        exp_st(32'h44, 32'h0000_0024, 4'b1111);
        exp_st(32'h48, 32'hFFFF_FF80, 4'b1111);
        exp_st(32'h4C, 32'h0000_0080, 4'b1111);
        exp_st(32'h06, 32'h0080_0080, 4'b1100);

        prog_b[0] = enc_i(7, 0, 3'b000, 0, 7'b0010011);
        prog_b[1] = enc_s(32'h40, 0, 0, 3'b010);
        prog_b[2] = enc_i(1, 0, 3'b000, 20, 7'b0010011);
        prog_b[3] = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_imem_req", imem_req_a, 0);
        check("rst_dmem_req", dmem_req_a, 0);
        check("rst_dmem_we", dmem_we_a, 0);
        check("rst_mask", {28'd0, dmem_mask_a}, 0);
        check("rst_retire", retire_a, 0);
        check("rst_pc", pc_a, 32'h0);
        check("rst_trap", {trap_a, trap_cause_a}, 0);
        reset_a = 1'b0;
        @(posedge clk); #1;
        check("fetch_req", imem_req_a, 1);
        check("fetch_addr", imem_addr_a, 32'h0);

        for (int i = 0; i < 400 && !trap_a; i++) begin @(posedge clk); #1; end
        check("mis_trap", trap_a, 1);
        check("mis_cause", {30'd0, trap_cause_a}, 32'd1);
        check("mis_pc", pc_a, 32'h44);
        check("mis_no_dreq", dmem_req_a, 0);
        check("loads_seen", loads_a, 2);
        check("ret_left", rt_q.size(), 0);
        check("st_left", st_q.size(), 0);
        hold_pc = pc_a;
        repeat (5) @(posedge clk); #1;
        check("trap_pc_frozen", pc_a, hold_pc);
        check("trap_imem_req", imem_req_a, 0);

        @(negedge clk);
        reset_a = 1'b1;
        dmem_en = 1'b0;
        prog_a[0] = enc_i(0, 0, 3'b010, 1, 7'b0000011);
        @(negedge clk);
        reset_a = 1'b0;
        reqcyc = 0;
        for (int i = 0; i < 100 && !trap_a; i++) begin
            @(negedge clk);
            if (dmem_req_a) reqcyc++;
        end
        check("tmo_trap", trap_a, 1);
        check("tmo_cause", {30'd0, trap_cause_a}, 32'd2);
        check("tmo_cycles", reqcyc, 16);
        check("tmo_req_off", dmem_req_a, 0);

        @(negedge clk); reset_a = 1'b1;
        @(negedge clk); reset_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin @(negedge clk); found = dmem_req_a; end
        check("mem_reached", found, 1);
        #2 reset_a = 1'b1;
        #1;
        check("rstmem_dmem_req", dmem_req_a, 0);
        check("rstmem_pc", pc_a, 32'h0);
        check("rstmem_trap", trap_a, 0);

        @(negedge clk); reset_b = 1'b0;
        for (int i = 0; i < 100 && !trap_b; i++) @(negedge clk);
        check("b_trap", trap_b, 1);
        check("b_cause", {30'd0, trap_cause_b}, 32'd3);
        check("b_pc", pc_b, 32'h08);
        check("b_stores", stores_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
